// File: rtl/ysyx_25040111_lsu_if.sv
// Request-side and AXI-side bundles for the LSU.
// req: arbiter (master) -> LSU (slave); axi: LSU (master) -> crossbar (slave).
// Pure wiring, no logic or latency of its own.

interface ysyx_25040111_lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [ADDR_W-1:0] lsu_raddr;
  logic [LEN_W-1:0]  lsu_rlen;
  logic              lsu_burst;
  logic [1:0]        lsu_rmask;
  logic              lsu_rsign;
  logic [31:0]       lsu_rdata;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [31:0]       lsu_wdata;
  logic [1:0]        lsu_wmask;
  logic              lsu_err;

  modport master (
    output lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
    output lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    input  lsu_rready, lsu_rdata, lsu_wready, lsu_err
  );

  modport slave (
    input  lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
    input  lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    output lsu_rready, lsu_rdata, lsu_wready, lsu_err
  );
endinterface

interface ysyx_25040111_axi_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040111_lsu.sv
// LSU: turns arbiter load/store requests into AXI4 AR/R or AW/W/B transactions.
// Latency: first lsu_rready / lsu_wready >= 2 cycles after request; one DONE cycle after completion.
// Backpressure: holds AXI valids until each handshake; arbiter holds its valid until the pulse.
// Option: define YSYX_25040111_LSU_MISALIGN_EN to reject misaligned single accesses with lsu_err.

module ysyx_25040111_lsu #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  ysyx_25040111_lsu_req_if.slave req,
  ysyx_25040111_axi_if.master    axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE, S_MIS
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              burst_q, burst_d;
  logic [1:0]        mask_q, mask_d;
  logic              sign_q, sign_d;
  logic              is_rd_q, is_rd_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       wdat_q, wdat_d;

  logic        lsu_rready_c, lsu_wready_c, lsu_err_c;
  logic [31:0] lsu_rdata_c;
  logic        arvalid_c, rready_c, awvalid_c, wvalid_c, bready_c;
  logic        beat_err;
  logic [1:0]  off;
  logic [2:0]  size_c;
  logic [3:0]  strb_base;
  logic [31:0] rd_shift, rd_fmt;
  logic        rd_mis, wr_mis;

  assign off = addr_q[1:0];

  // Misaligned single accesses are only trapped when the check is built in.
`ifdef YSYX_25040111_LSU_MISALIGN_EN
  assign rd_mis = !req.lsu_burst &&
                  ((req.lsu_rmask == 2'b01 && req.lsu_raddr[0]) ||
                   (req.lsu_rmask[1] && req.lsu_raddr[1:0] != 2'b00));
  assign wr_mis = (req.lsu_wmask == 2'b01 && req.lsu_waddr[0]) ||
                  (req.lsu_wmask[1] && req.lsu_waddr[1:0] != 2'b00);
`else
  assign rd_mis = 1'b0;
  assign wr_mis = 1'b0;
`endif

  // AXI size code and write strobe pattern from the latched size code.
  always_comb begin
    size_c    = 3'b000;
    strb_base = 4'b0001;
    if (burst_q || mask_q[1]) begin
      size_c    = 3'b010;
      strb_base = 4'b1111;
    end else if (mask_q[0]) begin
      size_c    = 3'b001;
      strb_base = 4'b0011;
    end
  end

  // Single-read lane alignment followed by zero/sign extension.
  always_comb begin
    rd_shift = axi.rdata >> {off, 3'b000};
    rd_fmt   = rd_shift;
    if (!mask_q[1]) begin
      if (mask_q[0])
        rd_fmt = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
      else
        rd_fmt = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
    end
  end

  // Beat is in error on a bad response or when rlast disagrees with the beat count.
  assign beat_err = (axi.rresp != 2'b00) || (axi.rlast != (cnt_q == len_q));

  // State register and latched request; reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= 1'b0;
      mask_q    <= 2'b00;
      sign_q    <= 1'b0;
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      mask_q    <= mask_d;
      sign_q    <= sign_d;
      is_rd_q   <= is_rd_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wdat_q    <= wdat_d;
    end
  end

  // Next-state and handshake outputs; read takes priority over write in IDLE.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    burst_d      = burst_q;
    mask_d       = mask_q;
    sign_d       = sign_q;
    is_rd_d      = is_rd_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wdat_d       = wdat_q;
    lsu_rready_c = 1'b0;
    lsu_wready_c = 1'b0;
    lsu_err_c    = 1'b0;
    lsu_rdata_c  = 32'h0;
    arvalid_c    = 1'b0;
    rready_c     = 1'b0;
    awvalid_c    = 1'b0;
    wvalid_c     = 1'b0;
    bready_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req.lsu_rvalid) begin
          addr_d  = req.lsu_raddr;
          len_d   = req.lsu_burst ? req.lsu_rlen : '0;
          burst_d = req.lsu_burst;
          mask_d  = req.lsu_rmask;
          sign_d  = req.lsu_rsign;
          is_rd_d = 1'b1;
          err_d   = 1'b0;
          state_d = rd_mis ? S_MIS : S_AR;
        end else if (req.lsu_wvalid) begin
          addr_d    = req.lsu_waddr;
          len_d     = '0;
          burst_d   = 1'b0;
          mask_d    = req.lsu_wmask;
          sign_d    = 1'b0;
          wdat_d    = req.lsu_wdata;
          is_rd_d   = 1'b0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr_mis ? S_MIS : S_AW_W;
        end
      end
      S_AR: begin
        arvalid_c = 1'b1;
        if (axi.arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        rready_c = 1'b1;
        if (axi.rvalid) begin
          lsu_rready_c = 1'b1;
          lsu_rdata_c  = burst_q ? axi.rdata : rd_fmt;
          cnt_d        = cnt_q + 1'b1;
          err_d        = err_q | beat_err;
          if (axi.rlast) begin
            lsu_err_c = err_q | beat_err;
            state_d   = S_DONE;
          end
        end
      end
      S_AW_W: begin
        awvalid_c = !aw_done_q;
        wvalid_c  = !w_done_q;
        aw_done_d = aw_done_q | (awvalid_c & axi.awready);
        w_done_d  = w_done_q | (wvalid_c & axi.wready);
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        bready_c = 1'b1;
        if (axi.bvalid) begin
          lsu_wready_c = 1'b1;
          lsu_err_c    = (axi.bresp != 2'b00);
          state_d      = S_DONE;
        end
      end
      S_MIS: begin
        lsu_rready_c = is_rd_q;
        lsu_wready_c = !is_rd_q;
        lsu_err_c    = 1'b1;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req.lsu_rready = lsu_rready_c;
  assign req.lsu_wready = lsu_wready_c;
  assign req.lsu_err    = lsu_err_c;
  assign req.lsu_rdata  = lsu_rdata_c;

  assign axi.arvalid = arvalid_c;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_c;
  assign axi.arburst = arvalid_c ? 2'b01 : 2'b00;
  assign axi.rready  = rready_c;
  assign axi.awvalid = awvalid_c;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = size_c;
  assign axi.wvalid  = wvalid_c;
  assign axi.wdata   = wdat_q << {off, 3'b000};
  assign axi.wstrb   = wvalid_c ? (strb_base << off) : 4'b0000;
  assign axi.wlast   = wvalid_c;
  assign axi.bready  = bready_c;

endmodule

// File: doc/ysyx_25040111_lsu.md
Name: ysyx_25040111_lsu

Overview:
- Responder for the arbiter's lsu_* read/write request interface; converts each request into an AXI4 master transaction on the system bus.
- Read path: single or burst AR/R transactions. Single reads return byte-lane-aligned, sign/zero-extended data; burst beats pass through unmodified. Write path: one AW/W/B transaction with strobe generation.
- Sits between the arbiter (instruction-cache refills and EXU loads/stores) and the AXI crossbar.

Parameters:
- ADDR_W, 32, address width for lsu_raddr/lsu_waddr/araddr/awaddr.
- LEN_W, 8, burst length field width (AXI4 arlen); the beat counter has this width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- lsu_rvalid  in  1  read request; held high until the final lsu_rready beat
- lsu_rready  out  1  one-cycle pulse per returned beat; lsu_rdata valid in that cycle
- lsu_raddr  in  ADDR_W  read byte address
- lsu_rlen  in  LEN_W  beats minus 1; used only when lsu_burst=1
- lsu_burst  in  1  1 = INCR burst of lsu_rlen+1 words
- lsu_rmask  in  2  00 byte, 01 half, 1x word
- lsu_rsign  in  1  sign-extend sub-word reads
- lsu_rdata  out  32  read data
- lsu_wvalid  in  1  write request; held until lsu_wready
- lsu_wready  out  1  one-cycle pulse when the B response is accepted
- lsu_waddr  in  ADDR_W  write byte address
- lsu_wdata  in  32  write data, right-aligned
- lsu_wmask  in  2  size code, same encoding as lsu_rmask
- lsu_err  out  1  pulses together with lsu_rready (last beat) or lsu_wready on an error
- AXI AR channel: arvalid out 1, arready in 1, araddr out ADDR_W, arlen out LEN_W, arsize out 3, arburst out 2
- AXI R channel: rvalid in 1, rready out 1, rdata in 32, rresp in 2, rlast in 1
- AXI AW channel: awvalid out 1, awready in 1, awaddr out ADDR_W, awsize out 3
- AXI W channel: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1
- AXI B channel: bvalid in 1, bready out 1, bresp in 2

Behaviour:
- Reset is asynchronous, active-high. On reset all outputs are 0, the FSM goes to IDLE, and the beat counter and error flag clear.
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - lsu_rvalid=1: latch request, go to AR. Read wins if lsu_rvalid and lsu_wvalid rise together.
  - Otherwise lsu_wvalid=1: latch request, go to AW_W.
- AR:
  - arvalid=1; araddr, arlen, arsize and arburst are stable until arready.
  - arlen = burst ? rlen : 0; arburst = 01 (INCR).
  - arsize = 010 for burst or word; otherwise 000 (byte) / 001 (half).
  - On arready, go to R and clear the beat counter.
- R:
  - rready=1. Each rvalid&rready produces lsu_rready=1 in the same cycle; lsu_rdata is combinational from rdata.
  - Single read: lsu_rdata = rdata >> (raddr[1:0]*8), then zero/sign-extended from bit 7 or 15 per rmask/rsign.
  - Burst read: lsu_rdata = raw rdata.
  - The beat counter increments on each beat.
  - rresp≠00 or an rlast mismatch (rlast early, or missing on beat arlen) sets the sticky error flag.
  - On rlast: go to DONE, and lsu_err = error flag in the final beat.
- AW_W:
  - awvalid, wvalid and wlast are asserted together. awsize is coded as for reads.
  - wdata = lsu_wdata << (waddr[1:0]*8).
  - wstrb = {0001, 0011, 1111}[mask] << waddr[1:0].
  - Each channel drops its valid after its own handshake (separate done flags). Go to B when both are done, in either order or the same cycle.
- B:
  - bready=1. On bvalid, lsu_wready=1 for one cycle and lsu_err = (bresp≠00); go to DONE.
- DONE:
  - One idle cycle to let the arbiter deassert its valid.
  - Returns to IDLE unconditionally; no request is accepted in DONE.
- Latency:
  - Read: first lsu_rready no earlier than 2 cycles after lsu_rvalid rises (arready and rvalid each ≥1 cycle).
  - Write: lsu_wready no earlier than 2 cycles after lsu_wvalid rises.
- Request inputs are sampled only in IDLE; later changes are ignored.
- Reset mid-transaction: the FSM aborts with no lsu_rready/lsu_wready pulse; AXI valids drop asynchronously.

Optional Feature:
- Macro: YSYX_25040111_LSU_MISALIGN_EN.
- Defined: a half request with addr[0]=1, or a word request with addr[1:0]≠0 (non-burst), issues no AXI transaction. Instead, after 1 cycle the block gives a single lsu_rready or lsu_wready pulse with lsu_err=1 and lsu_rdata=0.
- Undefined: no check. The address is passed unchanged; strobes shift out of range and are truncated to 4 bits.

Test Plan:
- Byte load signed: raddr=0x8000_0003, rmask=00, rsign=1, slave rdata=0x8A00_0000 -> arsize=000, one lsu_rready, lsu_rdata=0xFFFF_FF8A, lsu_err=0.
- Half load unsigned: raddr=0x...2, rmask=01, rdata=0xBEEF_0000 -> lsu_rdata=0x0000_BEEF.
- Burst read: burst=1, rlen=3, beats 0x11,0x22,0x33,0x44 with rvalid gaps -> arlen=3, arsize=010, exactly 4 lsu_rready pulses with raw data, DONE after the last.
- Store byte: waddr=0x...1, wmask=00, wdata=0x5A -> wstrb=0010, wdata=0x0000_5A00. With awready 3 cycles after wready, lsu_wready pulses once after bvalid.
- Error paths: rresp=10 on a single read -> lsu_err=1 with lsu_rready. Burst rlen=1 with rlast on beat 0 -> lsu_err=1, 1 pulse. bresp=11 -> lsu_err=1 with lsu_wready.
- Simultaneous lsu_rvalid and lsu_wvalid in IDLE -> read completes first, then the write. Reset asserted in R state -> all outputs 0 immediately, no completion pulse.
